// File: rtl/tcp_misc_pkg.sv
// Misc TCP helper types.
// Dequeue record and per-bit pend slot.
package tcp_misc_pkg;
  import tcp_pkg::*;

  typedef struct packed {
    logic [SCHED_FLOWID_W-1:0] flowid;
    logic                      ack_pend;
    logic                      data_pend;
    logic                      rt_pend;
  } sched_deq_struct;

  typedef struct packed {
    logic                   pend;
    logic [TIMESTAMP_W-1:0] ts;
  } pend_slot_struct;

endpackage

// File: rtl/tcp_pkg.sv
// Shared TCP engine types.
// Scheduler command format and timestamp width.
package tcp_pkg;

  localparam int TIMESTAMP_W    = 16;
  localparam int SCHED_FLOWID_W = 6;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    SET   = 2'd1,
    CLEAR = 2'd2
  } set_clear_e;

  typedef struct packed {
    logic [SCHED_FLOWID_W-1:0] flowid;
    set_clear_e                ack_cmd;
    set_clear_e                data_cmd;
    set_clear_e                rt_cmd;
    logic [TIMESTAMP_W-1:0]    timestamp;
  } sched_cmd_struct;

endpackage

// File: rtl/prio0_mux.sv
// Two-source mux, source 0 has fixed priority.
// Source 1 is back-pressured whenever source 0 is valid.
module prio0_mux #(
  parameter int W = 1
) (
  input  logic         val0,
  input  logic [W-1:0] data0,
  output logic         rdy0,
  input  logic         val1,
  input  logic [W-1:0] data1,
  output logic         rdy1,
  output logic         val,
  output logic [W-1:0] data
);

  assign rdy0 = 1'b1;
  assign rdy1 = ~val0;
  assign val  = val0 | val1;
  assign data = val0 ? data0 : data1;

endmodule

// File: rtl/tx_pend_slot_upd.sv
// Next-state for one pend bit and its timestamp.
// Scanner clear first, then the command on top.
module tx_pend_slot_upd
  import tcp_pkg::*;
  import tcp_misc_pkg::*;
(
  input  pend_slot_struct        cur_slot,
  input  logic                   scan_clr,
  input  set_clear_e             cmd,
  input  logic [TIMESTAMP_W-1:0] cmd_ts,
  output pend_slot_struct        nxt_slot
);

  // clear then apply command so the command wins
  always_comb begin
    nxt_slot = cur_slot;
    if (scan_clr) nxt_slot.pend = 1'b0;
    unique case (1'b1)
      (cmd == SET): begin
        nxt_slot.pend = 1'b1;
        nxt_slot.ts   = cmd_ts;
      end
      (cmd == CLEAR): nxt_slot.pend = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: rtl/tx_pend_sched.sv
// Per-flow tx pend table and round-robin dispatcher.
// Bits: 2 = ack, 1 = data, 0 = rt.
module tx_pend_sched
  import tcp_pkg::*;
  import tcp_misc_pkg::*;
#(
  parameter int MAX_FLOW_CNT = 64,
  parameter int FLOWID_W     = $clog2(MAX_FLOW_CNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            src0_cmd_val,
  input  sched_cmd_struct src0_cmd_data,
  output logic            src0_cmd_rdy,
  input  logic            src1_cmd_val,
  input  sched_cmd_struct src1_cmd_data,
  output logic            src1_cmd_rdy,
  output logic            sched_deq_val,
  output sched_deq_struct sched_deq_data,
  input  logic            sched_deq_rdy
);

  localparam int CW = $bits(sched_cmd_struct);

  localparam logic [0:0] SCAN   = 1'b0;
  localparam logic [0:0] OUTPUT = 1'b1;

  logic                   mux_val;
  logic [CW-1:0]          mux_data;
  logic                   cmd_val_q, cmd_val_d;
  sched_cmd_struct        cmd_q, cmd_d;
  logic [TIMESTAMP_W-1:0] tsc_q, tsc_d;
  logic [0:0]             state_q, state_d;
  logic [FLOWID_W-1:0]    idx_q, idx_d;
  sched_deq_struct        deq_q, deq_d;

  pend_slot_struct slot_q [MAX_FLOW_CNT][3];
  pend_slot_struct slot_d [MAX_FLOW_CNT][3];
  pend_slot_struct upd_slot [3];
  set_clear_e      fcmd [3];

  logic [2:0]          elig;
  logic                scan_fire;
  logic [FLOWID_W-1:0] cf;

  prio0_mux #(.W(CW)) u_arb (
    .val0  (src0_cmd_val),
    .data0 (src0_cmd_data),
    .rdy0  (src0_cmd_rdy),
    .val1  (src1_cmd_val),
    .data1 (src1_cmd_data),
    .rdy1  (src1_cmd_rdy),
    .val   (mux_val),
    .data  (mux_data)
  );

  assign cf      = cmd_q.flowid[FLOWID_W-1:0];
  assign fcmd[2] = cmd_q.ack_cmd;
  assign fcmd[1] = cmd_q.data_cmd;
  assign fcmd[0] = cmd_q.rt_cmd;

  // eligible bits of the flow under the scan index
  always_comb begin
    elig = '0;
    for (int b = 0; b < 3; b++) begin
      elig[b] = slot_q[idx_q][b].pend &&
                (slot_q[idx_q][b].ts <= tsc_q);
    end
  end

  assign scan_fire = (state_q == SCAN) && (|elig);

  for (genvar b = 0; b < 3; b++) begin : g_upd
    tx_pend_slot_upd u_upd (
      .cur_slot (slot_q[cf][b]),
      .scan_clr (scan_fire && (cf == idx_q) && elig[b]),
      .cmd      (fcmd[b]),
      .cmd_ts   (cmd_q.timestamp),
      .nxt_slot (upd_slot[b])
    );
  end

  // table write: scanner clear, then registered command
  always_comb begin
    slot_d = slot_q;
    if (scan_fire) begin
      for (int b = 0; b < 3; b++) begin
        if (elig[b]) slot_d[idx_q][b].pend = 1'b0;
      end
    end
    if (cmd_val_q) begin
      for (int b = 0; b < 3; b++) begin
        slot_d[cf][b] = upd_slot[b];
      end
    end
  end

  // command register, timestamp counter, scan fsm
  always_comb begin
    cmd_val_d = mux_val;
    cmd_d     = sched_cmd_struct'(mux_data);
    tsc_d     = tsc_q + 1'b1;
    state_d   = state_q;
    idx_d     = idx_q;
    deq_d     = deq_q;
    case (state_q)
      SCAN: begin
        if (|elig) begin
          deq_d.flowid    = SCHED_FLOWID_W'(idx_q);
          deq_d.ack_pend  = elig[2];
          deq_d.data_pend = elig[1];
          deq_d.rt_pend   = elig[0];
          state_d         = OUTPUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      OUTPUT: begin
        if (sched_deq_rdy) begin
          idx_d   = idx_q + 1'b1;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // state flops with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_val_q <= 1'b0;
      cmd_q     <= '0;
      tsc_q     <= '0;
      state_q   <= SCAN;
      idx_q     <= '0;
      deq_q     <= '0;
      for (int f = 0; f < MAX_FLOW_CNT; f++) begin
        for (int b = 0; b < 3; b++) begin
          slot_q[f][b] <= '0;
        end
      end
    end else begin
      cmd_val_q <= cmd_val_d;
      cmd_q     <= cmd_d;
      tsc_q     <= tsc_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      deq_q     <= deq_d;
      slot_q    <= slot_d;
    end
  end

  assign sched_deq_val  = (state_q == OUTPUT);
  assign sched_deq_data = deq_q;

endmodule

// File: tb/tb_tx_pend_sched.sv
// Directed bench for tx_pend_sched.
// Vector table plus multi-cycle corner sequences.
module tb_tx_pend_sched;
  import tcp_pkg::*;
  import tcp_misc_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            src0_cmd_val;
  sched_cmd_struct src0_cmd_data;
  logic            src0_cmd_rdy;
  logic            src1_cmd_val;
  sched_cmd_struct src1_cmd_data;
  logic            src1_cmd_rdy;
  logic            sched_deq_val;
  sched_deq_struct sched_deq_data;
  logic            sched_deq_rdy;

  tx_pend_sched dut (
    .clk            (clk),
    .rst            (rst),
    .src0_cmd_val   (src0_cmd_val),
    .src0_cmd_data  (src0_cmd_data),
    .src0_cmd_rdy   (src0_cmd_rdy),
    .src1_cmd_val   (src1_cmd_val),
    .src1_cmd_data  (src1_cmd_data),
    .src1_cmd_rdy   (src1_cmd_rdy),
    .sched_deq_val  (sched_deq_val),
    .sched_deq_data (sched_deq_data),
    .sched_deq_rdy  (sched_deq_rdy)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int unsigned cyc;

  typedef struct {
    logic [5:0]  f;
    logic        a;
    logic        d;
    logic        r;
    int unsigned c;
  } deq_rec_t;

  typedef struct {
    bit         src;
    logic [5:0] f;
    set_clear_e a;
    set_clear_e d;
    set_clear_e r;
    logic [2:0] mask;
  } vec_t;

  deq_rec_t log_q[$];
  deq_rec_t mon_r;
  vec_t     vt[6];

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst && sched_deq_val && sched_deq_rdy) begin
      mon_r.f = sched_deq_data.flowid;
      mon_r.a = sched_deq_data.ack_pend;
      mon_r.d = sched_deq_data.data_pend;
      mon_r.r = sched_deq_data.rt_pend;
      mon_r.c = cyc;
      log_q.push_back(mon_r);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input bit src, input logic [5:0] f,
                      input set_clear_e a, input set_clear_e d,
                      input set_clear_e r, input logic [15:0] ts);
    sched_cmd_struct c;
    c = '{flowid: f, ack_cmd: a, data_cmd: d,
          rt_cmd: r, timestamp: ts};
    @(posedge clk); #1;
    if (src) begin
      src1_cmd_val = 1'b1; src1_cmd_data = c;
    end else begin
      src0_cmd_val = 1'b1; src0_cmd_data = c;
    end
    @(posedge clk); #1;
    src0_cmd_val = 1'b0;
    src1_cmd_val = 1'b0;
  endtask

  task automatic wait_deq(input int budget, output bit found,
                          output deq_rec_t r);
    found = 1'b0;
    r = '{default: 0};
    for (int i = 0; i < budget; i++) begin
      if (log_q.size() > 0) begin
        r = log_q.pop_front();
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic expect_deq(input string nm, input int budget,
                            input logic [5:0] f,
                            input logic [2:0] mask);
    bit       found;
    deq_rec_t r;
    wait_deq(budget, found, r);
    chk({nm, " seen"}, found, 1);
    if (found) begin
      chk({nm, " id"}, r.f, f);
      chk({nm, " mask"}, {r.a, r.d, r.r}, mask);
    end
  endtask

  task automatic expect_none(input string nm, input int cycles);
    repeat (cycles) @(negedge clk);
    chk(nm, log_q.size(), 0);
    log_q.delete();
  endtask

  task automatic anchor(input logic [5:0] f);
    send(0, f, NOP, NOP, SET, 16'd0);
    expect_deq("anchor", 70, f, 3'b001);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    deq_rec_t    r;
    logic [15:0] t;

    vt[0] = '{1'b0, 6'd5,  NOP, NOP, SET, 3'b001};
    vt[1] = '{1'b1, 6'd10, SET, NOP, NOP, 3'b100};
    vt[2] = '{1'b0, 6'd20, SET, SET, NOP, 3'b110};
    vt[3] = '{1'b1, 6'd33, NOP, SET, SET, 3'b011};
    vt[4] = '{1'b0, 6'd63, SET, SET, SET, 3'b111};
    vt[5] = '{1'b1, 6'd0,  NOP, SET, NOP, 3'b010};

    rst = 1'b1;
    src0_cmd_val = 1'b0; src0_cmd_data = '0;
    src1_cmd_val = 1'b0; src1_cmd_data = '0;
    sched_deq_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst val", sched_deq_val, 0);
    chk("rst data", sched_deq_data, 0);
    chk("rst rdy0", src0_cmd_rdy, 1);
    chk("rst rdy1", src1_cmd_rdy, 1);
    src0_cmd_val = 1'b1;
    #1;
    chk("rst rdy1 blk", src1_cmd_rdy, 0);
    src0_cmd_val = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expect_none("idle none", 70);

    for (int i = 0; i < 6; i++) begin
      send(vt[i].src, vt[i].f, vt[i].a, vt[i].d, vt[i].r, 16'd0);
      expect_deq($sformatf("vec%0d", i), 70, vt[i].f, vt[i].mask);
      expect_none($sformatf("vec%0d once", i), i == 0 ? 200 : 80);
    end

    t = 16'(cyc + 100);
    send(1, 6'd3, NOP, SET, NOP, t);
    send(0, 6'd3, NOP, NOP, SET, 16'd0);
    expect_deq("fut rt", 70, 6'd3, 3'b001);
    wait_deq(200, found, r);
    chk("fut seen", found, 1);
    if (found) begin
      chk("fut id", r.f, 3);
      chk("fut mask", {r.a, r.d, r.r}, 3'b010);
      chk("fut early", r.c > 32'(t), 1);
      chk("fut late", r.c <= 32'(t) + 66, 1);
    end
    expect_none("fut once", 80);

    anchor(6'd40);
    @(posedge clk); #1;
    src0_cmd_val = 1'b1;
    src0_cmd_data = '{flowid: 6'd1, ack_cmd: SET, data_cmd: NOP,
                      rt_cmd: NOP, timestamp: 16'd0};
    src1_cmd_val = 1'b1;
    src1_cmd_data = '{flowid: 6'd2, ack_cmd: NOP, data_cmd: NOP,
                      rt_cmd: SET, timestamp: 16'd0};
    @(negedge clk);
    chk("sim rdy1 low", src1_cmd_rdy, 0);
    chk("sim rdy0", src0_cmd_rdy, 1);
    @(posedge clk); #1;
    src0_cmd_val = 1'b0;
    @(negedge clk);
    chk("sim rdy1 high", src1_cmd_rdy, 1);
    @(posedge clk); #1;
    src1_cmd_val = 1'b0;
    expect_deq("sim f1", 70, 6'd1, 3'b100);
    expect_deq("sim f2", 70, 6'd2, 3'b001);
    expect_none("sim once", 80);

    anchor(6'd30);
    send(0, 6'd7, SET, NOP, NOP, 16'd0);
    send(1, 6'd7, CLEAR, NOP, NOP, 16'd0);
    expect_none("setclr none", 140);

    anchor(6'd50);
    sched_deq_rdy = 1'b0;
    send(0, 6'd9, NOP, NOP, SET, 16'd0);
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sched_deq_val) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall seen", found, 1);
    chk("stall data0", sched_deq_data, {6'd9, 3'b001});
    send(0, 6'd9, NOP, NOP, SET, 16'd0);
    send(0, 6'd12, SET, NOP, NOP, 16'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall val", sched_deq_val, 1);
      chk("stall data", sched_deq_data, {6'd9, 3'b001});
      chk("stall rdy0", src0_cmd_rdy, 1);
    end
    chk("stall no hs", log_q.size(), 0);
    @(posedge clk); #1;
    sched_deq_rdy = 1'b1;
    expect_deq("stall rel", 5, 6'd9, 3'b001);
    expect_deq("stall f12", 70, 6'd12, 3'b100);
    expect_deq("stall f9 again", 70, 6'd9, 3'b001);
    expect_none("stall once", 80);

    anchor(6'd40);
    send(0, 6'd61, NOP, NOP, SET, 16'd0);
    send(1, 6'd63, SET, NOP, NOP, 16'd0);
    send(0, 6'd0, NOP, SET, NOP, 16'd0);
    expect_deq("wrap f61", 70, 6'd61, 3'b001);
    expect_deq("wrap f63", 70, 6'd63, 3'b100);
    expect_deq("wrap f0", 70, 6'd0, 3'b010);
    expect_none("wrap once", 80);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
